// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Each grant forwards up to MAX_BURST beats and stalls while the FIFO is full.
module fifo_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] last_id, last_n, grant_n;
  logic [BCW-1:0] beat_cnt, beat_cnt_n;
  logic [IDW-1:0] winner;
  logic           found;
  int unsigned    idx;

  assign busy = (state == GRANT);

  // Search starts just after the last granted index, so it ends up lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_id) + off) % NUM_REQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      last_id  <= last_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant_id;
    last_n       = last_id;
    beat_cnt_n   = beat_cnt;
    req_ready    = '0;
    fifo_write   = 1'b0;
    fifo_data_in = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = GRANT;
          grant_n    = winner;
          last_n     = winner;
          beat_cnt_n = '0;
        end
      end
      GRANT: begin
        req_ready[grant_id] = !fifo_full;
        fifo_write          = req_valid[grant_id] && !fifo_full;
        fifo_data_in        = req_data[grant_id*WIDTH +: WIDTH];
        if (!req_valid[grant_id]) begin
          state_n = IDLE;
        end else if (fifo_write) begin
          // The final beat leaves the count at MAX_BURST-1; the next grant clears it.
          if (beat_cnt == BCW'(MAX_BURST - 1)) state_n = IDLE;
          else                                  beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus a randomized
// end-to-end run against a queue-based FIFO and per-producer scoreboard.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        fifo_full;
  logic        full1 = 1'b0;

  logic [3:0]  req_ready,  req_ready_1;
  logic        fifo_write, fifo_write_1;
  logic [7:0]  fifo_data_in, fifo_data_in_1;
  logic [1:0]  grant_id, grant_id_1;
  logic        busy, busy_1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fq[$];

  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy));

  fifo_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_1), .fifo_full(full1), .fifo_write(fifo_write_1),
    .fifo_data_in(fifo_data_in_1), .grant_id(grant_id_1), .busy(busy_1));

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int off = 1; off <= 4; off++)
      if (v[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    checks++; if (fifo_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0b exp=0", fifo_write); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (fifo_data_in !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h exp=0", fifo_data_in); end
    @(posedge clk); #1 rst = 1'b0; req_valid = 4'b1001;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%0b exp=0", busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin failures++; $display("FAIL rst_first_grant got=%0d/%0b exp=0/1", grant_id, busy); end
    checks++; if (fifo_data_in !== 8'h11 || fifo_write !== 1'b1) begin failures++; $display("FAIL rst_first_data got=%0h exp=11", fifo_data_in); end
  endtask

  task automatic test_single_long();
    logic [8:1] ew = 8'b01101111;
    logic [8:1] eb = 8'b11101111;
    int sent = 0;
    do_reset();
    req_valid = 4'b0010; set_data(1, 8'hA0);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fifo_write !== 1'b0) begin failures++; $display("FAIL long_idle got=%0b/%0b exp=0/0", busy, fifo_write); end
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (fifo_write !== ew[c]) begin failures++; $display("FAIL long_write c=%0d got=%0b exp=%0b", c, fifo_write, ew[c]); end
      if (ew[c]) begin
        checks++; if (fifo_data_in !== 8'(8'hA0 + sent)) begin failures++; $display("FAIL long_data c=%0d got=%0h exp=%0h", c, fifo_data_in, 8'(8'hA0 + sent)); end
      end
      checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL long_gid c=%0d got=%0d exp=1", c, grant_id); end
      checks++; if (busy !== eb[c]) begin failures++; $display("FAIL long_busy c=%0d got=%0b exp=%0b", c, busy, eb[c]); end
      if (fifo_write) sent++;
      @(posedge clk); #1;
      if (sent >= 6) req_valid = '0;
      else set_data(1, 8'(8'hA0 + sent));
    end
  endtask

  task automatic test_round_robin();
    int cnt[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; set_data(i, 8'(i * 16)); end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (fifo_write_1 !== 1'b0) begin failures++; $display("FAIL rr_idle got=%0b exp=0", fifo_write_1); end
    @(posedge clk); #1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++; if (fifo_write_1 !== 1'(c % 2)) begin failures++; $display("FAIL rr_write c=%0d got=%0b exp=%0b", c, fifo_write_1, c % 2); end
      checks++; if (busy_1 !== 1'(c % 2)) begin failures++; $display("FAIL rr_busy c=%0d got=%0b exp=%0b", c, busy_1, c % 2); end
      if (c % 2 == 1) begin
        int p = ((c - 1) / 2) % 4;
        checks++; if (grant_id_1 !== 2'(p)) begin failures++; $display("FAIL rr_gid c=%0d got=%0d exp=%0d", c, grant_id_1, p); end
        checks++; if (fifo_data_in_1 !== 8'(p * 16 + cnt[p])) begin failures++; $display("FAIL rr_data c=%0d got=%0h exp=%0h", c, fifo_data_in_1, 8'(p * 16 + cnt[p])); end
      end
      for (int i = 0; i < 4; i++)
        if (req_ready_1[i] && req_valid[i]) cnt[i]++;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) set_data(i, 8'(i * 16 + cnt[i]));
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    fq.delete();
    for (int i = 0; i < 7; i++) fq.push_back(8'hEE);
    fifo_full = 1'b0;
    req_valid = 4'b0100; set_data(2, 8'hC0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (fifo_write !== 1'b1 || fifo_data_in !== 8'hC0) begin failures++; $display("FAIL stall_first got=%0b/%0h exp=1/c0", fifo_write, fifo_data_in); end
    @(posedge clk); #1;
    if (fifo_write) fq.push_back(8'hC0);
    fifo_full = (fq.size() == 8); set_data(2, 8'hC1);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL stall_full got=%0b exp=1", fifo_full); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (fifo_write !== 1'b0) begin failures++; $display("FAIL stall_write c=%0d got=%0b exp=0", c, fifo_write); end
      checks++; if (req_ready[2] !== 1'b0) begin failures++; $display("FAIL stall_ready c=%0d got=%0b exp=0", c, req_ready[2]); end
      checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL stall_hold c=%0d got=%0b/%0d exp=1/2", c, busy, grant_id); end
      checks++; if (u_dut.beat_cnt !== 3'd1) begin failures++; $display("FAIL stall_cnt c=%0d got=%0d exp=1", c, u_dut.beat_cnt); end
      @(posedge clk); #1;
    end
    void'(fq.pop_front());
    fifo_full = (fq.size() == 8);
    @(negedge clk);
    checks++; if (fifo_write !== 1'b1 || fifo_data_in !== 8'hC1) begin failures++; $display("FAIL stall_resume got=%0b/%0h exp=1/c1", fifo_write, fifo_data_in); end
    checks++; if (req_ready[2] !== 1'b1) begin failures++; $display("FAIL stall_resume_ready got=%0b exp=1", req_ready[2]); end
    @(posedge clk); #1;
    if (fifo_write) fq.push_back(8'hC1);
    fifo_full = (fq.size() == 8); set_data(2, 8'hC2);
    @(negedge clk);
    checks++; if (fifo_write !== 1'b0) begin failures++; $display("FAIL stall_refull got=%0b exp=0", fifo_write); end
    checks++; if (u_dut.beat_cnt !== 3'd2) begin failures++; $display("FAIL stall_cnt2 got=%0d exp=2", u_dut.beat_cnt); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    req_valid = 4'b1000; set_data(3, 8'hD0); set_data(0, 8'hE0);
    @(negedge clk);
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      checks++; if (fifo_write !== 1'b1 || fifo_data_in !== 8'(8'hD0 + b)) begin failures++; $display("FAIL drop_beat b=%0d got=%0b/%0h exp=1/%0h", b, fifo_write, fifo_data_in, 8'(8'hD0 + b)); end
      @(posedge clk); #1;
      set_data(3, 8'(8'hD1 + b));
    end
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (fifo_write !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drop_quiet got=%0b/%0b exp=0/1", fifo_write, busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fifo_write !== 1'b0) begin failures++; $display("FAIL drop_idle got=%0b/%0b exp=0/0", busy, fifo_write); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL drop_regrant got=%0b/%0d exp=1/0", busy, grant_id); end
    checks++; if (fifo_write !== 1'b1 || fifo_data_in !== 8'hE0) begin failures++; $display("FAIL drop_data got=%0b/%0h exp=1/e0", fifo_write, fifo_data_in); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0010; set_data(1, 8'hF0); set_data(3, 8'h33);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    set_data(1, 8'hF1);
    rst = 1'b1;
    #1;
    checks++; if (fifo_write !== 1'b0) begin failures++; $display("FAIL mid_write got=%0b exp=0", fifo_write); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_gid got=%0d exp=0", grant_id); end
    @(posedge clk); #1 rst = 1'b0; req_valid = 4'b1010;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%0b exp=0", busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL mid_prio got=%0d/%0b exp=1/1", grant_id, busy); end
    checks++; if (fifo_write !== 1'b1 || fifo_data_in !== 8'hF1) begin failures++; $display("FAIL mid_represent got=%0b/%0h exp=1/f1", fifo_write, fifo_data_in); end
  endtask

  task automatic test_end_to_end();
    int unsigned sent[4], rcvd[4];
    int          mlast, beats, exp_id, done;
    logic        prev_busy, wr, rd;
    logic [3:0]  idle_vld, last_vld, acc;
    logic [7:0]  wdata, d, expd;
    logic [1:0]  p;
    do_reset();
    fq.delete();
    for (int i = 0; i < 4; i++) begin sent[i] = 0; rcvd[i] = 0; end
    mlast = 3; beats = 0; prev_busy = 1'b0; idle_vld = '0; last_vld = '0; done = 0;
    for (int cyc = 0; cyc < 4000 && done == 0; cyc++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && sent[i] < 16 && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          set_data(i, {2'(i), 6'(sent[i])});
        end
      rd = (fq.size() > 0) && ($urandom_range(1, 0) == 1);
      @(negedge clk);
      checks++; if (fifo_write && fifo_full) begin failures++; $display("FAIL e2e_write_full cyc=%0d got=1 exp=0", cyc); end
      checks++; if ($countones(req_ready) > 1) begin failures++; $display("FAIL e2e_onehot cyc=%0d got=%b exp=<=1 bit", cyc, req_ready); end
      if (!prev_busy && last_vld != 0) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL e2e_latency cyc=%0d got=%0b exp=1", cyc, busy); end
      end
      if (busy && !prev_busy) begin
        exp_id = rr_pick(mlast, idle_vld);
        checks++; if (grant_id !== 2'(exp_id)) begin failures++; $display("FAIL e2e_fair cyc=%0d got=%0d exp=%0d", cyc, grant_id, exp_id); end
        mlast = exp_id; beats = 0;
      end
      if (fifo_write) begin
        p = grant_id;
        expd = {p, 6'(sent[p])};
        checks++; if (fifo_data_in !== expd) begin failures++; $display("FAIL e2e_wdata cyc=%0d got=%0h exp=%0h", cyc, fifo_data_in, expd); end
        beats++;
        checks++; if (beats > 4) begin failures++; $display("FAIL e2e_burst cyc=%0d got=%0d exp=<=4", cyc, beats); end
      end
      wr = fifo_write; wdata = fifo_data_in; acc = req_ready & req_valid;
      prev_busy = busy; last_vld = req_valid;
      if (!busy) idle_vld = req_valid;
      @(posedge clk); #1;
      if (rd) begin
        d = fq.pop_front();
        p = d[7:6];
        checks++; if (d[5:0] !== 6'(rcvd[p])) begin failures++; $display("FAIL e2e_order p=%0d got=%0d exp=%0d", p, d[5:0], rcvd[p]); end
        rcvd[p]++;
      end
      if (wr) fq.push_back(wdata);
      for (int i = 0; i < 4; i++)
        if (acc[i]) begin sent[i]++; req_valid[i] = 1'b0; end
      fifo_full = (fq.size() == 8);
      done = 1;
      for (int i = 0; i < 4; i++) if (rcvd[i] != 16) done = 0;
    end
    checks++; if (done == 0) begin failures++; $display("FAIL e2e_timeout got=incomplete exp=64 beats out"); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sent[i] != 16 || rcvd[i] != 16) begin failures++; $display("FAIL e2e_count p=%0d got=%0d/%0d exp=16/16", i, sent[i], rcvd[i]); end
    end
    checks++; if (fq.size() != 0) begin failures++; $display("FAIL e2e_extra got=%0d exp=0", fq.size()); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    test_reset();
    test_single_long();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_end_to_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
